acc_offload_dispatcher: RTL and testbench
=========================================

// Module: acc_offload_dispatcher
// PURPOSE
//  Decodes core offload requests against a parameterised table of offl_instr_t entries and builds operands.
//  Operands come from register-file values or immediates. Each accepted instruction is issued to the
//  accelerator over a valid/ready port. Tracks outstanding writebacks in a per-rd scoreboard plus a credit counter.
//  Sits between the core offload port and the accelerator request/response ports.
// PARAMETERS
//  NumInstr       4     number of offloadable instruction table entries
//  OfflInstr      '0    offl_instr_t [NumInstr-1:0]; entry i matches when (instr & instr_mask)==instr_data
//  DataWidth      32    operand width; immediates sign-extended to DataWidth
//  MaxOutstanding 4     max in-flight writeback instructions (>=1)
// PORTS
//  clk_i             in   1            clock, all state on rising edge
//  rst_i             in   1            synchronous reset, active-high
//  core_req_valid_i  in   1            core offers instruction
//  core_req_ready_o  out  1            dispatcher takes it this cycle
//  core_instr_i      in   32           instruction word
//  core_rs_i         in   3xDataWidth  rs1..rs3 values
//  core_rs_valid_i   in   3            rsN value valid
//  core_rsp_accept_o out  1            qualified by core handshake: 1=table hit, 0=illegal/not offloaded
//  core_rsp_wb_o     out  1            qualified by handshake: accepted instr writes rd
//  pending_rd_o      out  32           scoreboard, bit r = write to x[r] outstanding (bit0 always 0)
//  acc_req_valid_o   out  1            request to accelerator
//  acc_req_ready_i   in   1            accelerator accepts
//  acc_req_o         out  acc_req_t    {instr, op_a, op_b, op_c}
//  acc_rsp_valid_i   in   1            writeback returning; acc_rsp_ready_o tied 1
//  acc_rsp_rd_i      in   5            destination register of returning writeback
// BEHAVIOUR
//  Reset: FSM IDLE, acc_req_valid_o=0, acc_req_o='0, pending_rd_o=0, credit count=0, core_req_ready_o=0.
//  FSM IDLE:
//   - hit = lowest-index matching entry; wb = (writeback!=0) && rd!=0, rd=instr[11:7].
//   - ready = no hit, OR all use_rs bits have rs_valid, rd not pending (WAW) and, if wb, count<MaxOutstanding.
//   - Handshake on hit: latch acc_req_o, set pending_rd[rd] if wb, count+=wb, go ISSUE.
//   - Handshake on miss: accept_o=0, stay IDLE, no state change.
//  FSM ISSUE: acc_req_valid_o=1, acc_req_o stable until acc_req_ready_i; then IDLE. core_req_ready_o=0.
//  Latency: core handshake cycle N -> acc_req_valid_o high in N+1. Throughput 1 per 2 cycles.
//  Operand slot x (a/b/c): op_x_mux==OP_RS -> rs(x); OP_IMM -> imm(imm_x_mux) per RISC-V I/S/B/U/J, sign-extended.
//   Undefined enum values give 0.
//  Response: acc_rsp_valid_i clears pending_rd[acc_rsp_rd_i] and count-=1. Same-cycle accept+rsp: count unchanged,
//   clear applies to rsp rd, set to new rd. Rsp with rd not pending or count==0: ignored, assertion fires.
//  Reset mid-ISSUE drops the request (valid=0 next cycle). Count saturates at MaxOutstanding (never wraps).
// CONFIGURATION
//  ACC_DISPATCH_PIPE_EN defined:
//   - In ISSUE, core_req_ready_o may assert when acc_req_ready_i=1 (same readiness rules, counting the in-flight wb).
//   - A hit reloads acc_req_o and stays ISSUE: 1 instr/cycle back-to-back.
//  Undefined: behaviour exactly as above (2-cycle issue); ISSUE never asserts core_req_ready_o.
// STRUCTURE
//  acc_pkg gains: acc_req_t struct, imm_gen(instr, imm_sel_e) function, NumRs=3 constant.
//  Sub-module acc_operand_mux: one instance per operand slot, combinational imm gen + rs/imm select.
//  Table match and FSM stay in the top.
// TESTING
//  T1 table {data=0x0000000B,mask=0x0000007F,wb=1,use_rs=3'b011,a/b=OP_RS}: instr 0x00C5850B, rs1=5, rs2=7
//   -> accept=1, acc_req_valid_o N+1, op_a=5, op_b=7, pending_rd_o[10]=1.
//  T2 instr 0x00000033 (no match) -> accept=0 same cycle, acc_req_valid_o stays 0, scoreboard unchanged.
//  T3 OP_IMM+IMM_I, instr imm field 0xFFF -> op_a=32'hFFFFFFFF. IMM_U with 0xABCDE -> op_a=32'hABCDE000.
//  T4 acc_req_ready_i low 5 cycles -> acc_req_o held stable, core_req_ready_o=0 throughout; rises after accept.
//  T5 MaxOutstanding=2: third wb instr stalls until acc_rsp_valid_i clears one rd. Second instr to pending rd
//   stalls (WAW). Rsp and accept in same cycle -> count stays 2.
//  T6 rst_i asserted during ISSUE -> next cycle valid=0, pending_rd_o=0; PIPE_EN variant issues 4 instrs in 4 cycles.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the offload dispatcher: table entry, accelerator request,
// operand selectors and the RISC-V immediate generator.
package acc_pkg;

    localparam int unsigned NumRs        = 3;
    localparam int unsigned InstrWidth   = 32;
    localparam int unsigned AccDataWidth = 32;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RS   = 2'd1,
        OP_IMM  = 2'd2
    } op_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef struct packed {
        logic [InstrWidth-1:0] instr_data;
        logic [InstrWidth-1:0] instr_mask;
        logic                  writeback;
        logic [NumRs-1:0]      use_rs;
        op_sel_e               op_a_mux;
        op_sel_e               op_b_mux;
        op_sel_e               op_c_mux;
        imm_sel_e              imm_a_mux;
        imm_sel_e              imm_b_mux;
        imm_sel_e              imm_c_mux;
    } offl_instr_t;

    typedef struct packed {
        logic [InstrWidth-1:0]   instr;
        logic [AccDataWidth-1:0] op_a;
        logic [AccDataWidth-1:0] op_b;
        logic [AccDataWidth-1:0] op_c;
    } acc_req_t;

    // Only instr[31:7] carries immediate bits; result is sign-extended to 32 bits.
    function automatic logic [31:0] imm_gen(input logic [31:7] instr, input imm_sel_e sel);
        logic [31:0] imm;
        imm = '0;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/acc_operand_mux.sv
// One operand slot: selects the register value or a sign-extended immediate.
module acc_operand_mux
    import acc_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic [31:7]          instr,
    input  op_sel_e              op_sel,
    input  imm_sel_e             imm_sel,
    input  logic [DataWidth-1:0] rs,
    output logic [DataWidth-1:0] operand_c
);

    logic [31:0] imm;

    always_comb begin
        imm       = imm_gen(instr, imm_sel);
        operand_c = '0;
        case (op_sel)
            OP_RS:   operand_c = rs;
            OP_IMM:  operand_c = DataWidth'($signed(imm));
            default: operand_c = '0;
        endcase
    end

endmodule

// File: rtl/acc_offload_dispatcher.sv
// Decodes core offload requests, builds operands, issues them to the accelerator
// and tracks outstanding writebacks. ACC_DISPATCH_PIPE_EN enables back-to-back issue.
module acc_offload_dispatcher
    import acc_pkg::*;
#(
    parameter int unsigned                NumInstr       = 4,
    parameter offl_instr_t [NumInstr-1:0] OfflInstr      = '0,
    parameter int unsigned                DataWidth      = 32,
    parameter int unsigned                MaxOutstanding = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             core_req_valid_i,
    output logic                             core_req_ready_o,
    input  logic [InstrWidth-1:0]            core_instr_i,
    input  logic [NumRs-1:0][DataWidth-1:0]  core_rs_i,
    input  logic [NumRs-1:0]                 core_rs_valid_i,
    output logic                             core_rsp_accept_o,
    output logic                             core_rsp_wb_o,
    output logic [31:0]                      pending_rd_o,
    output logic                             acc_req_valid_o,
    input  logic                             acc_req_ready_i,
    output acc_req_t                         acc_req_o,
    input  logic                             acc_rsp_valid_i,
    output logic                             acc_rsp_ready_o,
    input  logic [4:0]                       acc_rsp_rd_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

    state_e         state_q, state_d;
    acc_req_t       req_q, req_d, new_req;
    logic [31:0]    pending_q, pending_d;
    logic [CntW-1:0] count_q, count_d;

    offl_instr_t    entry;
    logic           hit, wb, rs_ok, credit_ok, can_take, rsp_ok, take, take_wb;
    logic [4:0]     rd;
    logic [DataWidth-1:0] op_a, op_b, op_c;

    // Lowest-index matching table entry wins.
    always_comb begin
        hit   = 1'b0;
        entry = '0;
        for (int i = 0; i < int'(NumInstr); i++) begin
            if (!hit && ((core_instr_i & OfflInstr[i].instr_mask) == OfflInstr[i].instr_data)) begin
                hit   = 1'b1;
                entry = OfflInstr[i];
            end
        end
    end

    acc_operand_mux #(.DataWidth(DataWidth)) u_op_a (
        .instr(core_instr_i[31:7]), .op_sel(entry.op_a_mux), .imm_sel(entry.imm_a_mux),
        .rs(core_rs_i[0]), .operand_c(op_a)
    );
    acc_operand_mux #(.DataWidth(DataWidth)) u_op_b (
        .instr(core_instr_i[31:7]), .op_sel(entry.op_b_mux), .imm_sel(entry.imm_b_mux),
        .rs(core_rs_i[1]), .operand_c(op_b)
    );
    acc_operand_mux #(.DataWidth(DataWidth)) u_op_c (
        .instr(core_instr_i[31:7]), .op_sel(entry.op_c_mux), .imm_sel(entry.imm_c_mux),
        .rs(core_rs_i[2]), .operand_c(op_c)
    );

    // A legal response returning this cycle frees its credit for a same-cycle accept.
    always_comb begin
        rd        = core_instr_i[11:7];
        wb        = entry.writeback && (rd != 5'd0);
        rs_ok     = &(~entry.use_rs | core_rs_valid_i);
        rsp_ok    = acc_rsp_valid_i && pending_q[acc_rsp_rd_i] && (count_q != '0);
        credit_ok = (count_q < CntW'(MaxOutstanding)) || rsp_ok;
        can_take  = !rst_i && (!hit || (rs_ok && !pending_q[rd] && (!wb || credit_ok)));
        new_req   = '{instr: core_instr_i,
                      op_a:  AccDataWidth'(op_a),
                      op_b:  AccDataWidth'(op_b),
                      op_c:  AccDataWidth'(op_c)};
    end

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        pending_d        = pending_q;
        count_d          = count_q;
        core_req_ready_o = 1'b0;
        take             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                core_req_ready_o = can_take;
                if (core_req_valid_i && can_take && hit) begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (acc_req_ready_i) begin
                    state_d = ST_IDLE;
`ifdef ACC_DISPATCH_PIPE_EN
                    core_req_ready_o = can_take;
                    if (core_req_valid_i && can_take && hit) begin
                        take    = 1'b1;
                        state_d = ST_ISSUE;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        take_wb = take && wb;
        if (take) begin
            req_d = new_req;
        end

        // Clear before set: WAW stall guarantees the two never target the same rd.
        if (rsp_ok) begin
            pending_d[acc_rsp_rd_i] = 1'b0;
        end
        if (take_wb) begin
            pending_d[rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (take_wb && !rsp_ok) begin
            if (count_q != CntW'(MaxOutstanding)) begin
                count_d = count_q + CntW'(1);
            end
        end else if (!take_wb && rsp_ok) begin
            count_d = count_q - CntW'(1);
        end

        core_rsp_accept_o = core_req_valid_i && core_req_ready_o && hit;
        core_rsp_wb_o     = core_rsp_accept_o && wb;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign acc_req_valid_o = (state_q == ST_ISSUE);
    assign acc_req_o       = req_q;
    assign pending_rd_o    = pending_q;
    assign acc_rsp_ready_o = 1'b1;

`ifndef SYNTHESIS
    rsp_expected_a: assert property (@(posedge clk_i) disable iff (rst_i)
        acc_rsp_valid_i |-> (pending_q[acc_rsp_rd_i] && (count_q != '0)));
`endif

endmodule

// File: tb/tb_acc_offload_dispatcher.sv
// Directed bench for acc_offload_dispatcher: vector table plus hand-written
// stall, reset and throughput sequences (ACC_DISPATCH_PIPE_EN aware).
module tb_acc_offload_dispatcher;
    import acc_pkg::*;

    localparam offl_instr_t E0 = '{instr_data: 32'h0000000B, instr_mask: 32'h0000007F,
        writeback: 1'b1, use_rs: 3'b011, op_a_mux: OP_RS, op_b_mux: OP_RS, op_c_mux: OP_NONE,
        imm_a_mux: IMM_I, imm_b_mux: IMM_I, imm_c_mux: IMM_I};
    localparam offl_instr_t E1 = '{instr_data: 32'h0000002B, instr_mask: 32'h0000007F,
        writeback: 1'b1, use_rs: 3'b000, op_a_mux: OP_IMM, op_b_mux: OP_NONE, op_c_mux: OP_NONE,
        imm_a_mux: IMM_I, imm_b_mux: IMM_I, imm_c_mux: IMM_I};
    localparam offl_instr_t E2 = '{instr_data: 32'h0000005B, instr_mask: 32'h0000007F,
        writeback: 1'b0, use_rs: 3'b000, op_a_mux: OP_IMM, op_b_mux: OP_NONE, op_c_mux: OP_NONE,
        imm_a_mux: IMM_U, imm_b_mux: IMM_I, imm_c_mux: IMM_I};
    localparam offl_instr_t E3 = '{instr_data: 32'h0000007B, instr_mask: 32'h0000007F,
        writeback: 1'b1, use_rs: 3'b100, op_a_mux: OP_IMM, op_b_mux: OP_IMM, op_c_mux: OP_RS,
        imm_a_mux: IMM_S, imm_b_mux: IMM_J, imm_c_mux: IMM_I};
    localparam offl_instr_t [3:0] Table = {E3, E2, E1, E0};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             core_req_valid = 1'b0;
    logic             core_req_ready;
    logic [31:0]      core_instr = '0;
    logic [2:0][31:0] core_rs = '0;
    logic [2:0]       core_rs_valid = '0;
    logic             core_rsp_accept, core_rsp_wb;
    logic [31:0]      pending_rd;
    logic             acc_req_valid;
    logic             acc_req_ready = 1'b0;
    acc_req_t         acc_req;
    logic             acc_rsp_valid = 1'b0;
    logic             acc_rsp_ready;
    logic [4:0]       acc_rsp_rd = '0;

    acc_offload_dispatcher #(
        .NumInstr(4), .OfflInstr(Table), .DataWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_valid_i(core_req_valid), .core_req_ready_o(core_req_ready),
        .core_instr_i(core_instr), .core_rs_i(core_rs), .core_rs_valid_i(core_rs_valid),
        .core_rsp_accept_o(core_rsp_accept), .core_rsp_wb_o(core_rsp_wb),
        .pending_rd_o(pending_rd),
        .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready), .acc_req_o(acc_req),
        .acc_rsp_valid_i(acc_rsp_valid), .acc_rsp_ready_o(acc_rsp_ready), .acc_rsp_rd_i(acc_rsp_rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic respond(input logic [4:0] rd, input logic [31:0] exp_pending);
        @(negedge clk);
        acc_rsp_valid = 1'b1;
        acc_rsp_rd    = rd;
        @(negedge clk);
        acc_rsp_valid = 1'b0;
        #1;
        check("rsp_clear", pending_rd, exp_pending);
    endtask

    // Offer one instruction, expect it taken immediately, then let the accelerator accept it.
    task automatic issue_one(input logic [31:0] instr);
        @(negedge clk);
        core_req_valid = 1'b1;
        core_instr     = instr;
        #1;
        check("issue_ready", core_req_ready, 1);
        @(negedge clk);
        core_req_valid = 1'b0;
        acc_req_ready  = 1'b1;
        @(negedge clk);
        acc_req_ready  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1, rs2, rs3;
        logic [2:0]  rs_valid;
        logic        accept;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] op_a, op_b, op_c;
        logic [31:0] pending;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, seen, last_hs, exp_last;

        vecs[0] = '{instr: 32'h00C5850B, rs1: 32'd5, rs2: 32'd7, rs3: 32'h99, rs_valid: 3'b011,
                    accept: 1'b1, wb: 1'b1, rd: 5'd10, op_a: 32'd5, op_b: 32'd7, op_c: 32'd0,
                    pending: 32'h00000400};
        vecs[1] = '{instr: 32'h00000033, rs1: 32'd1, rs2: 32'd2, rs3: 32'd3, rs_valid: 3'b111,
                    accept: 1'b0, wb: 1'b0, rd: 5'd0, op_a: 32'd0, op_b: 32'd0, op_c: 32'd0,
                    pending: 32'h00000000};
        vecs[2] = '{instr: 32'hFFF002AB, rs1: 32'd1, rs2: 32'd2, rs3: 32'd3, rs_valid: 3'b000,
                    accept: 1'b1, wb: 1'b1, rd: 5'd5, op_a: 32'hFFFFFFFF, op_b: 32'd0, op_c: 32'd0,
                    pending: 32'h00000020};
        vecs[3] = '{instr: 32'hABCDE1DB, rs1: 32'd1, rs2: 32'd2, rs3: 32'd3, rs_valid: 3'b000,
                    accept: 1'b1, wb: 1'b0, rd: 5'd3, op_a: 32'hABCDE000, op_b: 32'd0, op_c: 32'd0,
                    pending: 32'h00000000};
        vecs[4] = '{instr: 32'h80000FFB, rs1: 32'd1, rs2: 32'd2, rs3: 32'h12345678, rs_valid: 3'b100,
                    accept: 1'b1, wb: 1'b1, rd: 5'd31, op_a: 32'hFFFFF81F, op_b: 32'hFFF00000,
                    op_c: 32'h12345678, pending: 32'h80000000};

        // Reset state, observed while reset is still held.
        @(negedge clk);
        #1;
        check("rst_ready", core_req_ready, 0);
        check("rst_valid", acc_req_valid, 0);
        check("rst_req", acc_req.instr, 0);
        check("rst_pending", pending_rd, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            core_req_valid = 1'b1;
            core_instr     = vecs[v].instr;
            core_rs[0]     = vecs[v].rs1;
            core_rs[1]     = vecs[v].rs2;
            core_rs[2]     = vecs[v].rs3;
            core_rs_valid  = vecs[v].rs_valid;
            #1;
            check("vec_ready", core_req_ready, 1);
            check("vec_accept", core_rsp_accept, vecs[v].accept);
            check("vec_wb", core_rsp_wb, vecs[v].wb);
            @(negedge clk);
            core_req_valid = 1'b0;
            #1;
            check("vec_issue_valid", acc_req_valid, vecs[v].accept);
            check("vec_pending", pending_rd, vecs[v].pending);
            if (vecs[v].accept) begin
                check("vec_instr", acc_req.instr, vecs[v].instr);
                check("vec_op_a", acc_req.op_a, vecs[v].op_a);
                check("vec_op_b", acc_req.op_b, vecs[v].op_b);
                check("vec_op_c", acc_req.op_c, vecs[v].op_c);
                acc_req_ready = 1'b1;
                @(negedge clk);
                acc_req_ready = 1'b0;
                #1;
                check("vec_valid_drop", acc_req_valid, 0);
            end
            if (vecs[v].wb) respond(vecs[v].rd, 32'h0);
        end

        // Accelerator back-pressure: request held, core stalled.
        core_rs[0] = 32'd5; core_rs[1] = 32'd7; core_rs_valid = 3'b011;
        @(negedge clk);
        core_req_valid = 1'b1;
        core_instr     = 32'h00C5850B;
        @(negedge clk);
        core_instr     = 32'h00000033;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", acc_req_valid, 1);
            check("bp_instr", acc_req.instr, 32'h00C5850B);
            check("bp_op_b", acc_req.op_b, 32'd7);
            check("bp_core_ready", core_req_ready, 0);
            @(negedge clk);
        end
        acc_req_ready = 1'b1;
        @(negedge clk);
        acc_req_ready = 1'b0;
        #1;
        check("bp_ready_after", core_req_ready, 1);
        check("bp_valid_after", acc_req_valid, 0);
        core_req_valid = 1'b0;
        respond(5'd10, 32'h0);

        // Credit limit (MaxOutstanding=2) and WAW stall.
        issue_one(32'h00C5850B);
        issue_one(32'hFFF002AB);
        @(negedge clk);
        core_req_valid = 1'b1;
        core_instr     = 32'hFFF0032B;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("credit_stall", core_req_ready, 0);
            @(negedge clk);
        end
        acc_rsp_valid = 1'b1;
        acc_rsp_rd    = 5'd10;
        #1;
        check("rsp_frees_credit", core_req_ready, 1);
        check("rsp_same_accept", core_rsp_accept, 1);
        @(negedge clk);
        acc_rsp_valid  = 1'b0;
        core_req_valid = 1'b0;
        acc_req_ready  = 1'b1;
        #1;
        check("same_cycle_pending", pending_rd, 32'h00000060);
        @(negedge clk);
        acc_req_ready  = 1'b0;
        core_req_valid = 1'b1;
        core_instr     = 32'hFFF003AB;
        #1;
        check("count_still_full", core_req_ready, 0);
        core_req_valid = 1'b0;
        respond(5'd6, 32'h00000020);
        @(negedge clk);
        core_req_valid = 1'b1;
        core_instr     = 32'hFFF002AB;
        #1;
        check("waw_stall", core_req_ready, 0);
        @(negedge clk);
        acc_rsp_valid = 1'b1;
        acc_rsp_rd    = 5'd5;
        @(negedge clk);
        acc_rsp_valid = 1'b0;
        #1;
        check("waw_release", core_req_ready, 1);
        check("waw_pending", pending_rd, 32'h0);
        @(negedge clk);
        core_req_valid = 1'b0;
        acc_req_ready  = 1'b1;
        @(negedge clk);
        acc_req_ready  = 1'b0;
        respond(5'd5, 32'h0);

        // Missing rs stalls; then reset during ISSUE drops the request.
        @(negedge clk);
        core_req_valid = 1'b1;
        core_instr     = 32'h00C5850B;
        core_rs_valid  = 3'b001;
        #1;
        check("rs_stall", core_req_ready, 0);
        core_rs_valid = 3'b011;
        #1;
        check("rs_ready", core_req_ready, 1);
        @(negedge clk);
        core_req_valid = 1'b0;
        #1;
        check("pre_rst_valid", acc_req_valid, 1);
        check("pre_rst_pending", pending_rd, 32'h00000400);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", acc_req_valid, 0);
        check("mid_rst_pending", pending_rd, 0);
        check("mid_rst_req", acc_req.instr, 0);

        // Four non-writeback instructions with the accelerator always ready.
        sent = 0; seen = 0; last_hs = -1;
        acc_req_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && seen < 4; cyc++) begin
            @(negedge clk);
            if (acc_req_valid) begin
                check("tp_op_a", acc_req.op_a, 32'((seen + 1) << 12));
                seen++;
            end
            core_req_valid = (sent < 4);
            core_instr     = 32'(((sent + 1) << 12) | 32'h5B);
            #1;
            if (core_req_valid && core_req_ready) begin
                sent++;
                last_hs = cyc;
            end
        end
`ifdef ACC_DISPATCH_PIPE_EN
        exp_last = 3;
`else
        exp_last = 6;
`endif
        check("tp_seen", 32'(seen), 32'd4);
        check("tp_last_hs", 32'(last_hs), 32'(exp_last));
        @(negedge clk);
        acc_req_ready  = 1'b0;
        core_req_valid = 1'b0;
        #1;
        check("tp_idle", acc_req_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
